// File: rtl/frame_send_ctrl.sv
// Frame sequencer for the PRBS generator: runs a programmable number of fixed-length
// frames, separated by idle gaps, at a bit rate of f_clk/(speedctr+1).
module frame_send_ctrl #(
    parameter int SPEED_W = 4,
    parameter int LEN_W   = 16,
    parameter int GAP_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [SPEED_W-1:0] speedctr,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic [CNT_W-1:0]   frame_num,
    input  logic [GAP_W-1:0]   gap_len,
    output logic               send_enable,
    output logic               bit_strobe,
    output logic               frame_start,
    output logic               frame_end,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   frames_sent,
    output logic               cfg_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d, div_q, div_d;
    logic [LEN_W-1:0]   len_q, len_d, bit_q, bit_d;
    logic [CNT_W-1:0]   num_q, num_d, cnt_q, cnt_d, cnt_inc, cnt_d_inc;
    logic [GAP_W-1:0]   gaplen_q, gaplen_d, gap_q, gap_d;
    logic               tick;
    logic               send_enable_d, bit_strobe_d, frame_start_d, frame_end_d;
    logic               busy_d, done_d, cfg_err_d;
    logic [CNT_W-1:0]   frames_sent_d;

    // Outputs are registered copies of the decode of the next state, so the output
    // registers always describe the current cycle and are reused below as such.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        speed_d   = speed_q;
        len_d     = len_q;
        num_d     = num_q;
        gaplen_d  = gaplen_q;
        div_d     = div_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        tick      = (div_q == speed_q);
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (frame_len == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        speed_d  = speedctr;
                        len_d    = frame_len;
                        num_d    = frame_num;
                        gaplen_d = gap_len;
                        div_d    = '0;
                        bit_d    = '0;
                        gap_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                div_d = tick ? '0 : div_q + SPEED_W'(1);
                if (bit_strobe) bit_d = bit_q + LEN_W'(1);
                if (frame_end) begin
                    cnt_d = cnt_inc;
                    bit_d = '0;
                    if (num_q != '0 && cnt_inc == num_q) begin
                        state_d = ST_DONE;
                    end else if (gaplen_q != '0) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
                // An abort still lets a coincident frame_end count its completed frame.
                if (stop) state_d = ST_IDLE;
            end
            ST_GAP: begin
                div_d = tick ? '0 : div_q + SPEED_W'(1);
                if (tick) begin
                    gap_d = gap_q + GAP_W'(1);
                    if (gap_d == gaplen_q) begin
                        bit_d   = '0;
                        state_d = ST_SEND;
                    end
                end
                if (stop) state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        send_enable_d = (state_d == ST_SEND);
        bit_strobe_d  = send_enable_d && (div_d == speed_d);
        frame_end_d   = bit_strobe_d && (bit_d == len_d - LEN_W'(1));
        frame_start_d = send_enable_d && (div_d == '0) && (bit_d == '0);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        cnt_d_inc     = (cnt_d == CNT_MAX) ? cnt_d : cnt_d + CNT_W'(1);
        frames_sent_d = frame_end_d ? cnt_d_inc : cnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // values from before the clock edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            speed_q     <= '0;
            len_q       <= '0;
            num_q       <= '0;
            gaplen_q    <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
            send_enable <= 1'b0;
            bit_strobe  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
            cfg_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            len_q       <= len_d;
            num_q       <= num_d;
            gaplen_q    <= gaplen_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            send_enable <= send_enable_d;
            bit_strobe  <= bit_strobe_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
            busy        <= busy_d;
            done        <= done_d;
            frames_sent <= frames_sent_d;
            cfg_err     <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_frame_send_ctrl.sv
// Self-checking bench for frame_send_ctrl: a timeline model derived from run arithmetic
// is compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_frame_send_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [3:0]  speedctr;
    logic [15:0] frame_len;
    logic [7:0]  frame_num;
    logic [15:0] gap_len;
    logic        send_enable, bit_strobe, frame_start, frame_end, busy, done, cfg_err;
    logic [7:0]  frames_sent;

    frame_send_ctrl #(.SPEED_W(4), .LEN_W(16), .GAP_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .speedctr(speedctr),
        .frame_len(frame_len), .frame_num(frame_num), .gap_len(gap_len),
        .send_enable(send_enable), .bit_strobe(bit_strobe), .frame_start(frame_start),
        .frame_end(frame_end), .busy(busy), .done(done), .frames_sent(frames_sent),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: a run is a timeline indexed by cycles since SEND entry.
    int  m_run = 0, m_t = 0, m_speed = 0, m_len = 0, m_num = 0, m_gap = 0, m_idle_frames = 0;
    bit  m_cfgerr = 1'b0;

    // Packed as {send_enable, bit_strobe, frame_start, frame_end, busy, done, cfg_err, frames_sent}
    function automatic logic [14:0] model_out();
        int p, f, g, per, idx, r, fr;
        logic se, st, fs, fe;
        if (m_run == 0) return {6'b0, m_cfgerr, 8'(m_idle_frames)};
        p   = m_speed + 1;
        f   = m_len * p;
        g   = m_gap * p;
        per = f + g;
        if (m_num != 0 && m_t == m_num * f + (m_num - 1) * g)
            return {4'b0, 1'b1, 1'b1, 1'b0, 8'(m_num)};
        idx = m_t / per;
        r   = m_t % per;
        if (r < f) begin
            se = 1'b1;
            st = ((r % p) == p - 1);
            fs = (r == 0);
            fe = (r == f - 1);
            fr = idx + (fe ? 1 : 0);
        end else begin
            se = 1'b0; st = 1'b0; fs = 1'b0; fe = 1'b0;
            fr = idx + 1;
        end
        if (fr > 255) fr = 255;
        return {se, st, fs, fe, 1'b1, 1'b0, 1'b0, 8'(fr)};
    endfunction

    int n_strobe = 0, n_fe = 0, n_fs = 0, n_done = 0, n_cfgerr = 0, n_gapcyc = 0;
    int run_len = 0, run_max = 0;

    always @(negedge clk) begin
        logic [14:0] e;
        e = model_out();
        if (rst) begin
            m_run = 0; m_idle_frames = 0; m_cfgerr = 1'b0;
        end else begin
            check("cycle", {send_enable, bit_strobe, frame_start, frame_end, busy, done,
                            cfg_err, frames_sent}, e);
            n_strobe += int'(bit_strobe);
            n_fe     += int'(frame_end);
            n_fs     += int'(frame_start);
            n_done   += int'(done);
            n_cfgerr += int'(cfg_err);
            n_gapcyc += int'(busy && !send_enable && !done);
            run_len   = bit_strobe ? run_len + 1 : 0;
            if (run_len > run_max) run_max = run_len;
            m_cfgerr = 1'b0;
            if (m_run == 0) begin
                if (start) begin
                    if (frame_len == 0) m_cfgerr = 1'b1;
                    else begin
                        m_run = 1; m_t = 0;
                        m_speed = int'(speedctr); m_len = int'(frame_len);
                        m_num = int'(frame_num); m_gap = int'(gap_len);
                    end
                end
            end else if (e[9] || stop) begin
                m_run = 0;
                m_idle_frames = int'(e[7:0]);
            end else begin
                m_t++;
            end
        end
    end

    task automatic set_cfg(input int sp, input int len, input int num, input int gap);
        speedctr  = 4'(sp);
        frame_len = 16'(len);
        frame_num = 8'(num);
        gap_len   = 16'(gap);
    endtask

    task automatic clear_counts();
        n_strobe = 0; n_fe = 0; n_fs = 0; n_done = 0; n_cfgerr = 0; n_gapcyc = 0;
        run_len = 0; run_max = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while (busy && i < budget) begin
            @(posedge clk); #2;
            i++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int i = 0;
        while (n_strobe < n && i < budget) begin
            @(posedge clk); #2;
            i++;
        end
        check("wait_strobes", n_strobe >= n, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        set_cfg(0, 0, 0, 0);
        #1 check("reset_state", {send_enable, bit_strobe, frame_start, frame_end, busy, done,
                                 cfg_err, frames_sent}, 15'd0);
        @(posedge clk); #2 rst = 1'b0;

        // Asynchronous reset in the middle of a long frame
        set_cfg(3, 100, 0, 0);
        clear_counts();
        pulse_start();
        wait_strobes(40, 400);
        rst = 1'b1;
        #1 check("async_reset", {send_enable, bit_strobe, frame_start, frame_end, busy, done,
                                 cfg_err, frames_sent}, 15'd0);
        @(posedge clk); #2 rst = 1'b0;
        set_cfg(0, 2, 1, 0);
        pulse_start();
        check("restart_first_cycle", {busy, send_enable, frame_start}, 3'b111);
        wait_idle("restart_idle", 50);

        // Back-to-back frames at full rate
        set_cfg(0, 8, 2, 0);
        clear_counts();
        pulse_start();
        wait_idle("b2b_idle", 100);
        check("b2b_strobes", n_strobe, 16);
        check("b2b_consecutive", run_max, 16);
        check("b2b_frame_end", n_fe, 2);
        check("b2b_frame_start", n_fs, 2);
        check("b2b_done", n_done, 1);
        check("b2b_frames_sent", frames_sent, 2);

        // Divided rate with gaps
        set_cfg(4, 5, 3, 2);
        clear_counts();
        pulse_start();
        wait_idle("gap_idle", 300);
        check("gap_strobes", n_strobe, 15);
        check("gap_low_cycles", n_gapcyc, 20);
        check("gap_frame_end", n_fe, 3);
        check("gap_done", n_done, 1);
        check("gap_frames_sent", frames_sent, 3);

        // Continuous run aborted by stop
        set_cfg(15, 4, 0, 0);
        clear_counts();
        pulse_start();
        wait_strobes(6, 300);
        stop = 1'b1;
        @(posedge clk); #2 stop = 1'b0;
        check("stop_send_enable", send_enable, 1'b0);
        check("stop_busy", busy, 1'b0);
        check("stop_frames_sent", frames_sent, 1);
        check("stop_no_done", n_done, 0);

        // Illegal start, then a start ignored during a run
        set_cfg(2, 0, 1, 0);
        clear_counts();
        pulse_start();
        @(posedge clk); #2;
        check("cfg_err_pulse", n_cfgerr, 1);
        check("cfg_err_busy", busy, 1'b0);
        set_cfg(1, 6, 2, 1);
        clear_counts();
        pulse_start();
        repeat (5) @(posedge clk);
        #2 set_cfg(0, 2, 1, 0);
        pulse_start();
        wait_idle("ignored_start_idle", 200);
        check("ignored_start_frames", frames_sent, 2);
        check("ignored_start_strobes", n_strobe, 12);

        // Stop coincident with the final frame_end
        set_cfg(0, 3, 1, 0);
        clear_counts();
        pulse_start();
        repeat (2) @(posedge clk);
        #2 stop = 1'b1;
        @(negedge clk);
        check("stop_fe_frame_end", frame_end, 1'b1);
        @(posedge clk); #2 stop = 1'b0;
        check("stop_fe_busy", busy, 1'b0);
        check("stop_fe_frames_sent", frames_sent, 1);
        check("stop_fe_no_done", n_done, 0);

        // Saturation of frames_sent in continuous mode
        set_cfg(0, 1, 0, 0);
        pulse_start();
        repeat (300) @(posedge clk);
        #2 check("sat_frames_sent", frames_sent, 255);
        stop = 1'b1;
        @(posedge clk); #2 stop = 1'b0;
        check("sat_after_stop", {busy, frames_sent}, {1'b0, 8'd255});

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            set_cfg($urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk); #2 start = 1'b0; stop = 1'b1;
        @(posedge clk); #2 stop = 1'b0;
        wait_idle("random_idle", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_send_ctrl.md
Name: frame_send_ctrl

Overview:
Sequences the PRBS data generator feeding the LVDS output. It takes a debounced start pulse and a latched configuration, then produces the send_enable and per-bit clock-enable strobe for the generator. It runs a programmable number of fixed-length frames separated by idle gaps, at bit rate f = f_clk/(speedctr+1). It sits between the debounce pulse and the data generator in the 10 MHz domain.

Parameters:
SPEED_W, 4, width of speedctr (rate divider; 0 = full clock rate, 15 = f_clk/16)
LEN_W, 16, width of frame_len and of the bit counter
GAP_W, 16, width of gap_len
CNT_W, 8, width of frame_num and frames_sent

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle start pulse (debounced button)
stop  in  1  single-cycle abort pulse
speedctr  in  SPEED_W  bit period = speedctr+1 clk cycles
frame_len  in  LEN_W  bits per frame; 0 is illegal
frame_num  in  CNT_W  frames per run; 0 = continuous until stop
gap_len  in  GAP_W  idle bit periods between frames; 0 = back-to-back
send_enable  out  1  high while a frame is being shifted out
bit_strobe  out  1  one-cycle enable per transmitted bit; only in SEND
frame_start  out  1  one-cycle pulse on the first cycle of each frame
frame_end  out  1  one-cycle pulse coincident with the last bit_strobe of a frame
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a finite run completes
frames_sent  out  CNT_W  completed frames in the current or last run
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs 0; frames_sent=0; all counters 0; config registers 0.
- States: IDLE, SEND, GAP, DONE. All outputs are registered.
- IDLE:
  - start with frame_len==0 -> cfg_err pulse the next cycle; remain in IDLE.
  - start with frame_len!=0 -> latch speedctr/frame_len/frame_num/gap_len, clear frames_sent, div_cnt and bit_cnt; next cycle enter SEND.
  - Config inputs are ignored outside IDLE; changes take effect only on the next start.
- SEND:
  - send_enable=1. frame_start=1 on the first cycle of each frame.
  - div_cnt counts 0..speed_l and wraps. bit_strobe=1 in the cycle where div_cnt==speed_l.
  - With speed_l=0, bit_strobe is high every cycle. First strobe occurs speed_l cycles after SEND entry.
  - bit_cnt increments on each strobe. The strobe with bit_cnt==len_l-1 also asserts frame_end, and frames_sent increments in the same cycle.
  - After frame_end:
    - If frame_num!=0 and frames_sent (post-increment) == frame_num -> DONE.
    - Else if gap_len!=0 -> GAP.
    - Else -> SEND again: bit_cnt=0, new frame_start next cycle, no dead cycle of send_enable.
- GAP:
  - send_enable=0, bit_strobe=0. div_cnt keeps running.
  - gap_cnt counts internal ticks (div_cnt==speed_l). After gap_len ticks -> SEND with fresh bit_cnt and div_cnt.
- DONE: done=1 for one cycle, then IDLE. frames_sent holds its value until the next accepted start.
- frames_sent saturates at all-ones in continuous mode and does not wrap.
- stop in SEND or GAP:
  - Next cycle: IDLE, send_enable=0, no frame_end, no done.
  - A partial frame is not counted.
  - stop in IDLE has no effect.
- Simultaneous events:
  - stop wins over a frame_end in the same cycle; frame_end and the count increment still occur for that completed bit.
  - start while busy is ignored.
  - start and stop together in IDLE: start wins.
- Counter widths must not overflow: bit_cnt is LEN_W, gap_cnt is GAP_W, div_cnt is SPEED_W; comparisons are done at full width.

Test Plan:
- Reset mid-SEND (speedctr=3, frame_len=100, after 40 strobes) -> all outputs 0 asynchronously; after release, start is accepted normally.
- speedctr=0, frame_len=8, frame_num=2, gap_len=0 -> 16 consecutive bit_strobe cycles; frame_end at strobes 8 and 16; 2 frame_start pulses; done; frames_sent=2.
- speedctr=4, frame_len=5, frame_num=3, gap_len=2 -> strobes every 5 cycles; send_enable low for 10 cycles between frames; done after 3rd frame_end; frames_sent=3.
- speedctr=15, frame_num=0, frame_len=4, stop after 6 strobes -> continuous run; frames_sent=1; send_enable low the cycle after stop; no done.
- start with frame_len=0 -> cfg_err pulse; busy stays 0. Second start pulse during a run -> ignored; config unchanged.
- stop coincident with final frame_end (frame_num=1) -> frame_end=1, frames_sent=1, state IDLE, done=0.
